// File: rtl/pll_clock_divider_if.sv
// Control and status bundle for the PLL c0 clock divider.
// The controller drives clkena and observes the divided clock and lock status.
interface pll_clock_divider_if;
    logic clkena;
    logic c0;
    logic locked;

    modport master (
        output clkena,
        input  c0,
        input  locked
    );

    modport slave (
        input  clkena,
        output c0,
        output locked
    );
endinterface

// File: rtl/pll_clock_divider.sv
// Integer clock divider with programmable high time, phase offset and a lock indicator.
// c0 is registered, so it is glitch-free, and it stays low until the block has locked.
module pll_clock_divider #(
    parameter int unsigned DIV_RATIO    = 2,
    parameter int unsigned HIGH_CYCLES  = 1,
    parameter int unsigned PHASE_CYCLES = 0,
    parameter int unsigned LOCK_CYCLES  = 64
) (
    input  logic                 clk,
    input  logic                 areset_n,
    pll_clock_divider_if.slave   bus
);

    if (DIV_RATIO < 2 || DIV_RATIO > 1024) begin : g_bad_div
        $fatal(1, "pll_clock_divider: DIV_RATIO %0d outside 2..1024", DIV_RATIO);
    end
    if (HIGH_CYCLES < 1 || HIGH_CYCLES > DIV_RATIO - 1) begin : g_bad_high
        $fatal(1, "pll_clock_divider: HIGH_CYCLES %0d outside 1..DIV_RATIO-1", HIGH_CYCLES);
    end
    if (PHASE_CYCLES > DIV_RATIO - 1) begin : g_bad_phase
        $fatal(1, "pll_clock_divider: PHASE_CYCLES %0d outside 0..DIV_RATIO-1", PHASE_CYCLES);
    end
    if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : g_bad_lock
        $fatal(1, "pll_clock_divider: LOCK_CYCLES %0d outside 1..65535", LOCK_CYCLES);
    end

    localparam int unsigned LockW  = $clog2(LOCK_CYCLES + 1);
    localparam int unsigned PhaseW = $clog2(DIV_RATIO);
    // One extra bit so the modulo subtraction never wraps inside the slot arithmetic.
    localparam int unsigned SlotW  = PhaseW + 1;

    localparam logic [LockW-1:0]  LockMax  = LockW'(LOCK_CYCLES);
    localparam logic [PhaseW-1:0] PhaseMax = PhaseW'(DIV_RATIO - 1);
    localparam logic [SlotW-1:0]  SlotDiv  = SlotW'(DIV_RATIO);
    localparam logic [SlotW-1:0]  SlotLast = SlotW'(DIV_RATIO - 1);
    localparam logic [SlotW-1:0]  SlotOff  = SlotW'(PHASE_CYCLES);
    localparam logic [SlotW-1:0]  SlotHigh = SlotW'(HIGH_CYCLES);

    logic [LockW-1:0]  lock_cnt_q,  lock_cnt_d;
    logic              locked_q,    locked_d;
    logic [PhaseW-1:0] phase_cnt_q, phase_cnt_d;
    logic              en_q,        en_d;
    logic              c0_q,        c0_d;
    logic [SlotW-1:0]  phase_ext;
    logic [SlotW-1:0]  slot;

    always_comb begin
        phase_ext = {1'b0, phase_cnt_q};
        if (phase_ext >= SlotOff) begin
            slot = phase_ext - SlotOff;
        end else begin
            slot = phase_ext + SlotDiv - SlotOff;
        end
    end

    always_comb begin
        lock_cnt_d  = lock_cnt_q;
        locked_d    = locked_q;
        phase_cnt_d = '0;
        en_d        = en_q;

        if (lock_cnt_q < LockMax) begin
            lock_cnt_d = lock_cnt_q + LockW'(1);
        end
        if (lock_cnt_d == LockMax) begin
            locked_d = 1'b1;
        end

        if (locked_q) begin
            phase_cnt_d = (phase_cnt_q == PhaseMax) ? '0 : phase_cnt_q + PhaseW'(1);
        end

        // Once locked, enable changes only land on the last slot of a period.
        if (!locked_q || slot == SlotLast) begin
            en_d = bus.clkena;
        end

        c0_d = locked_q & en_q & (slot < SlotHigh);
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            lock_cnt_q  <= '0;
            locked_q    <= 1'b0;
            phase_cnt_q <= '0;
            en_q        <= 1'b0;
            c0_q        <= 1'b0;
        end else begin
            lock_cnt_q  <= lock_cnt_d;
            locked_q    <= locked_d;
            phase_cnt_q <= phase_cnt_d;
            en_q        <= en_d;
            c0_q        <= c0_d;
        end
    end

    assign bus.c0     = c0_q;
    assign bus.locked = locked_q;

endmodule

// File: tb/tb_pll_clock_divider.sv
// Directed bench: four divider configurations share one clock and reset; each edge is
// checked against hand-computed lock and c0 patterns, then an async reset is exercised.
module tb_pll_clock_divider;

    logic clk;
    logic areset_n;
    int   checks;
    int   errors;
    int   n;

    // Bit n holds the expected c0 value just after edge n (edges 1..24).
    logic [31:0] exp_c0_d1;
    logic [31:0] exp_c0_d2;
    logic [31:0] exp_c0_d3;

    pll_clock_divider_if if0 ();
    pll_clock_divider_if if1 ();
    pll_clock_divider_if if2 ();
    pll_clock_divider_if if3 ();

    pll_clock_divider u_d0 (
        .clk      (clk),
        .areset_n (areset_n),
        .bus      (if0.slave)
    );

    pll_clock_divider #(
        .DIV_RATIO    (5),
        .HIGH_CYCLES  (2),
        .PHASE_CYCLES (0),
        .LOCK_CYCLES  (4)
    ) u_d1 (
        .clk      (clk),
        .areset_n (areset_n),
        .bus      (if1.slave)
    );

    pll_clock_divider #(
        .DIV_RATIO    (5),
        .HIGH_CYCLES  (2),
        .PHASE_CYCLES (3),
        .LOCK_CYCLES  (4)
    ) u_d2 (
        .clk      (clk),
        .areset_n (areset_n),
        .bus      (if2.slave)
    );

    pll_clock_divider #(
        .DIV_RATIO    (4),
        .HIGH_CYCLES  (2),
        .PHASE_CYCLES (0),
        .LOCK_CYCLES  (4)
    ) u_d3 (
        .clk      (clk),
        .areset_n (areset_n),
        .bus      (if3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s at edge %0d: observed %b expected %b", tag, n, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        n         = 0;
        exp_c0_d1 = 32'h0031_8C60;  // edges 5,6,10,11,15,16,20,21
        exp_c0_d2 = 32'h018C_6300;  // edges 8,9,13,14,18,19,23,24
        exp_c0_d3 = 32'h0066_0660;  // edges 5,6,9,10,17,18,21,22

        areset_n   = 1'b0;
        if0.clkena = 1'b1;
        if1.clkena = 1'b1;
        if2.clkena = 1'b1;
        if3.clkena = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_c0_d0", if0.c0, 1'b0);
        check("reset_locked_d0", if0.locked, 1'b0);
        check("reset_c0_d1", if1.c0, 1'b0);
        check("reset_locked_d1", if1.locked, 1'b0);
        @(negedge clk);
        areset_n = 1'b1;

        for (int e = 1; e <= 70; e++) begin
            step();
            check("d0_locked", if0.locked, n >= 64);
            check("d0_c0", if0.c0, (n >= 65) && ((n - 65) % 2 == 0));
            if (n <= 24) begin
                check("d1_locked", if1.locked, n >= 4);
                check("d1_c0", if1.c0, exp_c0_d1[n]);
                check("d2_c0", if2.c0, exp_c0_d2[n]);
                check("d3_locked", if3.locked, n >= 4);
                check("d3_c0", if3.c0, exp_c0_d3[n]);
            end
            // d3: drop mid-high window, single-cycle pulse off-boundary, raise mid-period
            if (n == 9)  if3.clkena = 1'b0;
            if (n == 10) if3.clkena = 1'b1;
            if (n == 11) if3.clkena = 1'b0;
            if (n == 14) if3.clkena = 1'b1;
        end

        // Edge 70: d1 is in slot 0 with c0 high.
        check("pre_reset_c0_d1", if1.c0, 1'b1);
        check("pre_reset_locked_d1", if1.locked, 1'b1);
        areset_n = 1'b0;
        #1;
        check("async_c0_d1", if1.c0, 1'b0);
        check("async_locked_d1", if1.locked, 1'b0);
        check("async_locked_d0", if0.locked, 1'b0);
        check("async_locked_d3", if3.locked, 1'b0);
        #2;
        areset_n = 1'b1;
        n = 0;

        for (int e = 1; e <= 66; e++) begin
            step();
            check("relock_d0", if0.locked, n >= 64);
            if (n <= 12) begin
                check("relock_d1", if1.locked, n >= 4);
                check("relock_c0_d1", if1.c0, n == 5 || n == 6 || n == 10 || n == 11);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
